lcd_read_fsm: RTL and testbench

- 4-bit-mode read transaction engine for the HD44780-style character LCD. It is the read-direction counterpart of the existing instruction (write) engine.
- Drives LCD_RS / LCD_RW=1 / LCD_E, releases the SF_D[11:8] nibble bus, samples the upper then lower nibble, and assembles a byte.
- Status reads (RS=0) yield busy flag (BF) plus address counter; data reads (RS=1) yield DDRAM/CGRAM data.
- Sits beside the write engine under the LCD controller top. The top grants bus ownership via `start` and muxes LCD pins by `active`.

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_nibble_timer.sv | 28 ++
 rtl/lcd_read_fsm.sv | 199 +++++++++++++++++++
 tb/tb_lcd_read_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD engines: state encodings,
// default timing constants and the RS/RW control field layout.
package lcd_pkg;

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_SETUP_HIGH  = 4'd1;
    localparam logic [3:0] S_ACTIVE_HIGH = 4'd2;
    localparam logic [3:0] S_HOLD_HIGH   = 4'd3;
    localparam logic [3:0] S_GAP         = 4'd4;
    localparam logic [3:0] S_SETUP_LOW   = 4'd5;
    localparam logic [3:0] S_ACTIVE_LOW  = 4'd6;
    localparam logic [3:0] S_HOLD_LOW    = 4'd7;
    localparam logic [3:0] S_DONE        = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE        = S_IDLE,
        ST_SETUP_HIGH  = S_SETUP_HIGH,
        ST_ACTIVE_HIGH = S_ACTIVE_HIGH,
        ST_HOLD_HIGH   = S_HOLD_HIGH,
        ST_GAP         = S_GAP,
        ST_SETUP_LOW   = S_SETUP_LOW,
        ST_ACTIVE_LOW  = S_ACTIVE_LOW,
        ST_HOLD_LOW    = S_HOLD_LOW,
        ST_DONE        = S_DONE
    } lcd_state_t;

    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_E_HIGH  = 12;
    localparam int DEF_T_HOLD    = 1;
    localparam int DEF_T_GAP     = 50;
    localparam int DEF_T_DONE    = 2;
    localparam int DEF_MAX_POLLS = 255;

    localparam int TIMER_W     = 12;
    localparam int CTRL_W      = 2;
    localparam int CTRL_RS_BIT = 1;
    localparam int CTRL_RW_BIT = 0;

endpackage

// File: rtl/lcd_nibble_timer.sv
// Phase timer for the LCD engines: free-running count with synchronous clear
// and a terminal-count flag on the last cycle of a phase of length 'limit'.
module lcd_nibble_timer
    import lcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [TIMER_W-1:0] limit,
    output logic               tc
);

    logic [TIMER_W-1:0] count_r;

    // Phase counter, restarted by the owning FSM on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (clear) begin
            count_r <= {TIMER_W{1'b0}};
        end else begin
            count_r <= count_r + {{(TIMER_W-1){1'b0}}, 1'b1};
        end
    end

    assign tc = (count_r == (limit - {{(TIMER_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/lcd_read_fsm.sv
// 4-bit-mode LCD read engine: status (RS=0) or data (RS=1) byte read.
// Optional busy-flag polling is enabled by defining LCD_BUSY_POLL_EN.
module lcd_read_fsm
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_E_HIGH = DEF_T_E_HIGH,
    parameter int T_HOLD   = DEF_T_HOLD,
    parameter int T_GAP    = DEF_T_GAP,
    parameter int T_DONE   = DEF_T_DONE
`ifdef LCD_BUSY_POLL_EN
    , parameter int MAX_POLLS = DEF_MAX_POLLS
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_sel,
    input  logic [3:0] sf_d_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       sf_d_oe,
    output logic       active,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr,
    output logic       timeout
);

    lcd_state_t         state_r;
    lcd_state_t         next_state_s;
    logic [TIMER_W-1:0] limit_s;
    logic               tc_s;
    logic               clear_s;
    logic               rs_lat_r;
    logic               rs_next_s;
    logic [CTRL_W-1:0]  ctrl_s;
    logic               done_entry_s;
    logic               done_gate_s;
    logic               poll_loop_s;

    lcd_nibble_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .limit (limit_s),
        .tc    (tc_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and phase-length selection
    always_comb begin
        next_state_s = state_r;
        limit_s      = {{(TIMER_W-1){1'b0}}, 1'b1};
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_SETUP_HIGH;
                else       next_state_s = ST_IDLE;
            end
            ST_SETUP_HIGH: begin
                limit_s = TIMER_W'(T_SETUP);
                if (tc_s) next_state_s = ST_ACTIVE_HIGH;
                else      next_state_s = ST_SETUP_HIGH;
            end
            ST_ACTIVE_HIGH: begin
                limit_s = TIMER_W'(T_E_HIGH);
                if (tc_s) next_state_s = ST_HOLD_HIGH;
                else      next_state_s = ST_ACTIVE_HIGH;
            end
            ST_HOLD_HIGH: begin
                limit_s = TIMER_W'(T_HOLD);
                if (tc_s) next_state_s = ST_GAP;
                else      next_state_s = ST_HOLD_HIGH;
            end
            // The gap also separates successive polls; then it restarts the upper nibble
            ST_GAP: begin
                limit_s = TIMER_W'(T_GAP);
                if (tc_s && poll_loop_s) next_state_s = ST_SETUP_HIGH;
                else if (tc_s)           next_state_s = ST_SETUP_LOW;
                else                     next_state_s = ST_GAP;
            end
            ST_SETUP_LOW: begin
                limit_s = TIMER_W'(T_SETUP);
                if (tc_s) next_state_s = ST_ACTIVE_LOW;
                else      next_state_s = ST_SETUP_LOW;
            end
            ST_ACTIVE_LOW: begin
                limit_s = TIMER_W'(T_E_HIGH);
                if (tc_s) next_state_s = ST_HOLD_LOW;
                else      next_state_s = ST_ACTIVE_LOW;
            end
            ST_HOLD_LOW: begin
                limit_s = TIMER_W'(T_HOLD);
                if (tc_s) next_state_s = ST_DONE;
                else      next_state_s = ST_HOLD_LOW;
            end
            ST_DONE: begin
                limit_s = TIMER_W'(T_DONE);
                if (tc_s && poll_loop_s) next_state_s = ST_GAP;
                else if (tc_s)           next_state_s = ST_IDLE;
                else                     next_state_s = ST_DONE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign clear_s      = (next_state_s != state_r) || (state_r == ST_IDLE);
    assign done_entry_s = (state_r == ST_HOLD_LOW) && (next_state_s == ST_DONE);

    // RS/RW for the upcoming cycle; RS comes straight from rs_sel on the accepting edge
    always_comb begin
        ctrl_s    = {CTRL_W{1'b0}};
        rs_next_s = (state_r == ST_IDLE) ? rs_sel : rs_lat_r;
        if (next_state_s == ST_IDLE) begin
            ctrl_s = {CTRL_W{1'b0}};
        end else begin
            ctrl_s[CTRL_RS_BIT] = rs_next_s;
            ctrl_s[CTRL_RW_BIT] = 1'b1;
        end
    end

    // Registered pin, handshake and capture outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            active    <= 1'b0;
            done      <= 1'b0;
            rs_lat_r  <= 1'b0;
            rd_data   <= 8'h00;
            busy_flag <= 1'b0;
            addr      <= 7'h00;
        end else begin
            lcd_e  <= (next_state_s == ST_ACTIVE_HIGH) || (next_state_s == ST_ACTIVE_LOW);
            lcd_rs <= ctrl_s[CTRL_RS_BIT];
            lcd_rw <= ctrl_s[CTRL_RW_BIT];
            active <= (next_state_s != ST_IDLE);
            done   <= done_entry_s && done_gate_s;
            if ((state_r == ST_IDLE) && start) rs_lat_r <= rs_sel;
            if ((state_r == ST_ACTIVE_HIGH) && tc_s) rd_data[7:4] <= sf_d_in;
            if ((state_r == ST_ACTIVE_LOW) && tc_s)  rd_data[3:0] <= sf_d_in;
            if (done_entry_s && !rs_lat_r) begin
                busy_flag <= rd_data[7];
                addr      <= rd_data[6:0];
            end
        end
    end

    assign sf_d_oe = 1'b0;

`ifdef LCD_BUSY_POLL_EN
    logic [7:0] poll_cnt_r;
    logic       repoll_r;
    logic       bf_s;
    logic       limit_hit_s;

    assign bf_s        = !rs_lat_r && rd_data[7];
    assign limit_hit_s = (poll_cnt_r >= 8'(MAX_POLLS - 1));
    assign done_gate_s = !bf_s || limit_hit_s;
    assign poll_loop_s = repoll_r;

    // Busy-poll bookkeeping: decide at DONE entry, count each restart out of GAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt_r <= 8'h00;
            repoll_r   <= 1'b0;
            timeout    <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            poll_cnt_r <= 8'h00;
            repoll_r   <= 1'b0;
            timeout    <= 1'b0;
        end else if (done_entry_s) begin
            repoll_r <= bf_s && !limit_hit_s;
            timeout  <= bf_s && limit_hit_s;
        end else if ((state_r == ST_GAP) && (next_state_s == ST_SETUP_HIGH)) begin
            repoll_r   <= 1'b0;
            poll_cnt_r <= poll_cnt_r + 8'h01;
        end
    end
`else
    assign done_gate_s = 1'b1;
    assign poll_loop_s = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Directed self-checking bench for lcd_read_fsm; cycle 0 is the cycle start is driven.
module tb_lcd_read_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rs_sel;
    logic [3:0] sf_d_in;
    logic       lcd_e, lcd_rs, lcd_rw, sf_d_oe, active, done, busy_flag, timeout;
    logic [7:0] rd_data;
    logic [6:0] addr;

    int n_checks = 0;
    int n_fail   = 0;

    // observations collected by run_read
    int         done_cnt, done_cyc, e_rise_cnt, rs_bad, rw_bad, oe_bad, act_cnt, act_first;
    int         e_rise[2];
    int         e_len[2];
    logic [7:0] rd_at_done, rd_mid;
    logic       bf_at_done;
    logic [6:0] addr_at_done;

`ifdef LCD_BUSY_POLL_EN
    lcd_read_fsm #(.MAX_POLLS(4)) dut (
`else
    lcd_read_fsm dut (
`endif
        .clk(clk), .reset(reset), .start(start), .rs_sel(rs_sel), .sf_d_in(sf_d_in),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .sf_d_oe(sf_d_oe),
        .active(active), .done(done), .rd_data(rd_data), .busy_flag(busy_flag),
        .addr(addr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // One read; the bus shows 'up' only on cycle 14 and 'lo' only on cycle 79, junk elsewhere
    task automatic run_read(input logic rs, input logic [3:0] up, input logic [3:0] lo,
                            input int n_cyc, input int p0, input int p1, input int p2);
        logic e_prev;
        done_cnt = 0; done_cyc = -1; e_rise_cnt = 0; rs_bad = 0; rw_bad = 0; oe_bad = 0;
        act_cnt = 0; act_first = -1; e_len[0] = 0; e_len[1] = 0; e_rise[0] = -1; e_rise[1] = -1;
        rd_at_done = 8'h00; rd_mid = 8'h00; bf_at_done = 1'b0; addr_at_done = 7'h00;
        e_prev = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        rs_sel = rs;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clk);
            start = (c == p0 || c == p1 || c == p2) ? 1'b1 : 1'b0;
            if (lcd_e && !e_prev) begin
                if (e_rise_cnt < 2) e_rise[e_rise_cnt] = c;
                e_rise_cnt++;
            end
            if (lcd_e && e_rise_cnt >= 1 && e_rise_cnt <= 2) e_len[e_rise_cnt-1]++;
            e_prev = lcd_e;
            if (done) begin
                done_cnt++;
                done_cyc     = c;
                rd_at_done   = rd_data;
                bf_at_done   = busy_flag;
                addr_at_done = addr;
            end
            if (c == 40) rd_mid = rd_data;
            if (active) begin
                act_cnt++;
                if (act_first < 0) act_first = c;
                if (lcd_rs !== rs) rs_bad++;
                if (lcd_rw !== 1'b1) rw_bad++;
            end else if (lcd_rw !== 1'b0 || lcd_rs !== 1'b0) begin
                rw_bad++;
            end
            if (sf_d_oe !== 1'b0) oe_bad++;
            sf_d_in = (c == 14) ? up : (c == 79) ? lo : (c[3:0] ^ 4'hA);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; rs_sel = 1'b0; sf_d_in = 4'h0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({lcd_e, lcd_rs, lcd_rw, sf_d_oe, active, done, timeout} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {lcd_e, lcd_rs, lcd_rw, sf_d_oe, active, done, timeout});
        end
        n_checks++;
        if ({rd_data, busy_flag, addr} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got rd_data=%h bf=%b addr=%h expected all 0", rd_data, busy_flag, addr);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({lcd_e, lcd_rw, active, done} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 0000", {lcd_e, lcd_rw, active, done});
        end
    endtask

    task automatic test_status_read();
        run_read(1'b0, 4'h8, 4'h3, 95, -1, -1, -1);
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL status_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_cyc !== 81) begin n_fail++; $display("FAIL status_latency: got %0d expected 81", done_cyc); end
        n_checks++; if (rd_at_done !== 8'h83) begin n_fail++; $display("FAIL status_rd_data: got %h expected 83", rd_at_done); end
        n_checks++; if (bf_at_done !== 1'b1) begin n_fail++; $display("FAIL status_busy_flag: got %b expected 1", bf_at_done); end
        n_checks++; if (addr_at_done !== 7'h03) begin n_fail++; $display("FAIL status_addr: got %h expected 03", addr_at_done); end
        n_checks++; if (e_rise_cnt !== 2) begin n_fail++; $display("FAIL e_pulse_count: got %0d expected 2", e_rise_cnt); end
        n_checks++; if (e_rise[0] !== 3) begin n_fail++; $display("FAIL e_rise_upper: got %0d expected 3", e_rise[0]); end
        n_checks++; if (e_rise[1] !== 68) begin n_fail++; $display("FAIL e_rise_lower: got %0d expected 68", e_rise[1]); end
        n_checks++; if (e_len[0] !== 12 || e_len[1] !== 12) begin n_fail++; $display("FAIL e_width: got %0d,%0d expected 12,12", e_len[0], e_len[1]); end
        n_checks++; if (act_first !== 1 || act_cnt !== 82) begin n_fail++; $display("FAIL status_active: got first=%0d len=%0d expected 1,82", act_first, act_cnt); end
        n_checks++; if (rs_bad !== 0 || rw_bad !== 0) begin n_fail++; $display("FAIL status_rs_rw: got %0d,%0d bad cycles expected 0,0", rs_bad, rw_bad); end
        n_checks++; if (oe_bad !== 0) begin n_fail++; $display("FAIL status_oe: got %0d cycles driven expected 0", oe_bad); end
    endtask

    task automatic test_data_read();
        run_read(1'b1, 4'h4, 4'h1, 95, -1, -1, -1);
        n_checks++; if (done_cyc !== 81 || done_cnt !== 1) begin n_fail++; $display("FAIL data_done: got cyc=%0d cnt=%0d expected 81,1", done_cyc, done_cnt); end
        n_checks++; if (rd_at_done !== 8'h41) begin n_fail++; $display("FAIL data_rd_data: got %h expected 41", rd_at_done); end
        n_checks++; if (rd_mid !== 8'h43) begin n_fail++; $display("FAIL lower_nibble_kept: got %h expected 43", rd_mid); end
        n_checks++; if (busy_flag !== 1'b1 || addr !== 7'h03) begin n_fail++; $display("FAIL data_status_kept: got bf=%b addr=%h expected 1,03", busy_flag, addr); end
        n_checks++; if (rs_bad !== 0 || rw_bad !== 0 || oe_bad !== 0) begin n_fail++; $display("FAIL data_pins: got rs=%0d rw=%0d oe=%0d bad expected 0", rs_bad, rw_bad, oe_bad); end
    endtask

    task automatic test_back_to_back();
        run_read(1'b0, 4'h2, 4'h5, 100, 10, 80, 82);
        n_checks++; if (done_cnt !== 1 || done_cyc !== 81) begin n_fail++; $display("FAIL ignore_start_done: got cnt=%0d cyc=%0d expected 1,81", done_cnt, done_cyc); end
        n_checks++; if (act_cnt !== 82 || active !== 1'b0) begin n_fail++; $display("FAIL ignore_start_active: got len=%0d now=%b expected 82,0", act_cnt, active); end
        n_checks++; if (bf_at_done !== 1'b0 || addr_at_done !== 7'h25) begin n_fail++; $display("FAIL b2b_status: got bf=%b addr=%h expected 0,25", bf_at_done, addr_at_done); end
        run_read(1'b1, 4'h6, 4'h9, 90, -1, -1, -1);
        n_checks++; if (done_cyc !== 81 || rd_at_done !== 8'h69) begin n_fail++; $display("FAIL next_start: got cyc=%0d rd=%h expected 81,69", done_cyc, rd_at_done); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got %b expected 0", timeout); end
    endtask

    task automatic test_reset_mid();
        int dcnt;
        dcnt = 0;
        sf_d_in = 4'h7;
        @(negedge clk);
        start = 1'b1; rs_sel = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++; if (lcd_e !== 1'b1) begin n_fail++; $display("FAIL mid_e_before: got %b expected 1", lcd_e); end
        reset = 1'b1;
        #1;
        n_checks++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL abort_e: got %b expected 0", lcd_e); end
        n_checks++;
        if ({lcd_rs, lcd_rw, active, done, busy_flag, addr, rd_data} !== 19'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rs=%b rw=%b act=%b done=%b bf=%b addr=%h rd=%h expected all 0",
                     lcd_rs, lcd_rw, active, done, busy_flag, addr, rd_data);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        n_checks++; if (dcnt !== 0 || active !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got done=%0d active=%b expected 0,0", dcnt, active); end
    endtask

`ifdef LCD_BUSY_POLL_EN
    // Status poll: upper nibble carries BF=1 for the first bf_reads reads, then 0x1
    task automatic run_poll(input int bf_reads, input int n_cyc);
        int   pulses;
        logic e_prev;
        pulses = 0; done_cnt = 0; e_prev = 1'b0; rd_at_done = 8'h00;
        @(negedge clk);
        start = 1'b1; rs_sel = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (lcd_e && !e_prev) begin
                if (pulses % 2 == 1)         sf_d_in = 4'h0;
                else if (pulses / 2 < bf_reads) sf_d_in = 4'h8;
                else                          sf_d_in = 4'h1;
                pulses++;
            end
            e_prev = lcd_e;
            if (done) begin
                done_cnt++;
                rd_at_done = rd_data;
                bf_at_done = timeout;
            end
        end
        e_rise_cnt = pulses;
    endtask

    task automatic test_busy_poll();
        run_poll(3, 800);
        n_checks++; if (done_cnt !== 1 || e_rise_cnt !== 8) begin n_fail++; $display("FAIL poll_done: got done=%0d e=%0d expected 1,8", done_cnt, e_rise_cnt); end
        n_checks++; if (rd_at_done !== 8'h10 || bf_at_done !== 1'b0) begin n_fail++; $display("FAIL poll_result: got rd=%h to=%b expected 10,0", rd_at_done, bf_at_done); end
        run_poll(100, 800);
        n_checks++; if (done_cnt !== 1 || bf_at_done !== 1'b1) begin n_fail++; $display("FAIL poll_timeout: got done=%0d to=%b expected 1,1", done_cnt, bf_at_done); end
        run_read(1'b1, 4'h4, 4'h1, 90, -1, -1, -1);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_status_read();
        test_data_read();
        test_back_to_back();
        test_reset_mid();
`ifdef LCD_BUSY_POLL_EN
        test_busy_poll();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
